// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and constants for the RV32M multiply/divide unit
package mdu_pkg;
    localparam int XLEN_DEF = 32;
    localparam logic [XLEN_DEF-1:0] INT_MIN = 32'h8000_0000;
    localparam logic [XLEN_DEF-1:0] NEG_ONE = 32'hFFFF_FFFF;
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_e;
    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } mdu_state_e;
endpackage

// File: rtl/mdu_div_core.sv
// mdu_div_core: radix-2 restoring divider datapath on unsigned magnitudes
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_load            capture dividend/divisor, clear partial remainder
//   i_step            perform one shift/trial-subtract iteration
//   i_dividend        dividend magnitude
//   i_divisor         divisor magnitude
//   o_quot, o_rem     quotient and remainder magnitudes
module mdu_div_core
    import mdu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_load,
    input  logic            i_step,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_quot,
    output logic [XLEN-1:0] o_rem
);
    logic [XLEN-1:0] r_quot, r_rem, r_dsr;
    logic [XLEN:0]   w_sh, w_diff;
    logic            w_ge;
    // quotient register doubles as the dividend shift register
    assign w_sh   = {r_rem, r_quot[XLEN-1]};
    assign w_diff = w_sh - {1'b0, r_dsr};
    assign w_ge   = !w_diff[XLEN];
    assign o_quot = r_quot;
    assign o_rem  = r_rem;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_quot <= '0;
            r_rem  <= '0;
            r_dsr  <= '0;
        end else if (i_load) begin
            r_quot <= i_dividend;
            r_rem  <= '0;
            r_dsr  <= i_divisor;
        end else if (i_step) begin
            r_rem  <= w_ge ? w_diff[XLEN-1:0] : w_sh[XLEN-1:0];
            r_quot <= {r_quot[XLEN-2:0], w_ge};
        end
    end
endmodule

// File: rtl/mdu_unit.sv
// mdu_unit: RV32M multiply/divide unit with fixed 2-cycle multiply and iterative divide
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_start           request, sampled only in IDLE
//   i_op              funct3 operation code
//   i_src_a, i_src_b  rs1/rs2 operands
//   i_kill            abort in-flight operation
//   o_busy            registered stall request to the hazard unit
//   o_done            registered single-cycle result-valid pulse
//   o_result          registered result, held until the next o_done
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = 6
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_src_a,
    input  logic [XLEN-1:0] i_src_b,
    input  logic            i_kill,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);
    mdu_state_e        r_state;
    mdu_op_e           r_op;
    logic [XLEN-1:0]   r_a, r_b, r_result;
    logic [CNT_W-1:0]  r_cnt;
    logic [2*XLEN-1:0] r_prod;
    logic              r_busy, r_done;
    logic              w_accept, w_sgn_in, w_fast_in, w_step, w_sa, w_sb;
    logic              w_sdiv, w_div0, w_ovf;
    logic [XLEN-1:0]   w_dvd, w_dsr, w_cq, w_cr, w_q, w_r;
    logic [2*XLEN-1:0] w_ma, w_mb, w_prod;
    assign w_accept  = r_state == S_IDLE && i_start && !i_kill;
    assign w_sgn_in  = !i_op[0];
    assign w_fast_in = i_src_b == '0 || (w_sgn_in && i_src_a == INT_MIN && i_src_b == NEG_ONE);
    assign w_dvd     = (w_sgn_in && i_src_a[XLEN-1]) ? -i_src_a : i_src_a;
    assign w_dsr     = (w_sgn_in && i_src_b[XLEN-1]) ? -i_src_b : i_src_b;
    assign w_step    = r_state == S_DIV && r_cnt != CNT_W'(XLEN) && !i_kill;
    // low 2*XLEN bits of the product do not depend on signedness once operands are extended
    assign w_sa   = r_op[1:0] != 2'b11;
    assign w_sb   = !r_op[1];
    assign w_ma   = {{XLEN{w_sa & r_a[XLEN-1]}}, r_a};
    assign w_mb   = {{XLEN{w_sb & r_b[XLEN-1]}}, r_b};
    assign w_prod = w_ma * w_mb;
    assign w_sdiv = !r_op[0];
    assign w_div0 = r_b == '0;
    assign w_ovf  = w_sdiv && r_a == INT_MIN && r_b == NEG_ONE;
    assign w_q    = w_div0 ? NEG_ONE : w_ovf ? INT_MIN : (w_sdiv && (r_a[XLEN-1] ^ r_b[XLEN-1])) ? -w_cq : w_cq;
    assign w_r    = w_div0 ? r_a : w_ovf ? '0 : (w_sdiv && r_a[XLEN-1]) ? -w_cr : w_cr;
    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_result = r_result;
    mdu_div_core #(.XLEN(XLEN)) u_div (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_accept),
        .i_step     (w_step),
        .i_dividend (w_dvd),
        .i_divisor  (w_dsr),
        .o_quot     (w_cq),
        .o_rem      (w_cr)
    );
    // r_busy low on the first cycle of MUL/FIX marks the extra cycle that gives the fixed 2-cycle latency
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_op     <= OP_MUL;
            r_a      <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_prod   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else if (i_kill && r_state inside {S_MUL, S_DIV, S_FIX}) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_op    <= mdu_op_e'(i_op);
                    r_a     <= i_src_a;
                    r_b     <= i_src_b;
                    r_cnt   <= '0;
                    r_state <= !i_op[2] ? S_MUL : w_fast_in ? S_FIX : S_DIV;
                end
                S_MUL: if (!r_busy) begin
                    r_busy <= 1'b1;
                    r_prod <= w_prod;
                end else begin
                    r_result <= r_op == OP_MUL ? r_prod[XLEN-1:0] : r_prod[2*XLEN-1:XLEN];
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= S_DONE;
                end
                S_DIV: begin
                    r_busy <= 1'b1;
                    if (r_cnt == CNT_W'(XLEN)) r_state <= S_FIX;
                    else r_cnt <= r_cnt + CNT_W'(1);
                end
                S_FIX: if (!r_busy) begin
                    r_busy <= 1'b1;
                end else begin
                    r_result <= r_op[1] ? w_r : w_q;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= S_DONE;
                end
                S_DONE: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- RV32M multiply/divide unit in the EXECUTE stage, beside the ALU. Operands come from the DECODE-to-EXECUTE register; the result goes to the EXECUTE-to-MEMORY register.
- Multiply: fixed 2-cycle latency. Divide/remainder: iterative radix-2 restoring division, one quotient bit per cycle.
- BUSY drives the hazard unit. While BUSY is high, the hazard unit deasserts EN on the FETCH/DECODE registers and inserts bubbles via CLR on EXECUTE-to-MEMORY.

Parameters:
XLEN, 32, operand/result width
CNT_W, 6, iteration counter width (must hold XLEN+1)

Ports:
CLK  in  1  clock; all state updates on posedge
RST  in  1  reset, synchronous, active-high
START  in  1  request; sampled only in IDLE
OP  in  3  funct3: MUL=000 MULH=001 MULHSU=010 MULHU=011 DIV=100 DIVU=101 REM=110 REMU=111
SRC_A  in  XLEN  rs1 operand (forwarded value)
SRC_B  in  XLEN  rs2 operand (forwarded value)
KILL  in  1  abort in-flight op (branch flush)
BUSY  out  1  registered; high in MUL, DIV and FIX states
DONE  out  1  registered single-cycle pulse; RESULT valid
RESULT  out  XLEN  registered result; holds until the next DONE

Behaviour:
- Reset (RST sampled high): state=IDLE, BUSY=0, DONE=0, RESULT=0, counter=0, internal regs=0. RST overrides START and KILL in every state, including mid-divide.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE:
  - START=1 latches OP, SRC_A and SRC_B.
  - OP[2]=0 goes to MUL.
  - OP[2]=1 with SRC_B==0 (divide by zero) goes to FIX, fast path.
  - DIV/REM with SRC_A==0x80000000 and SRC_B==0xFFFFFFFF (overflow) goes to FIX, fast path.
  - Any other divide goes to DIV with counter=0.
- MUL:
  - Computes the 64-bit product of 33-bit extended operands.
  - Extension: A signed for MUL/MULH/MULHSU; B signed for MUL/MULH; zero-extended otherwise.
  - RESULT = low 32 bits for MUL, high 32 bits for the rest. Then DONE=1, go to DONE.
- DIV:
  - Operates on magnitudes; the divisor is absolute only for signed ops.
  - Each cycle: shift remainder/quotient left, trial subtract, set quotient bit; counter++.
  - After XLEN iterations (counter==XLEN) go to FIX.
- FIX:
  - Signed ops: quotient negated if sign(A) xor sign(B); remainder takes sign(A).
  - Divide by zero: quotient = 0xFFFFFFFF (DIV and DIVU); remainder = SRC_A.
  - Overflow: quotient = 0x80000000, remainder = 0.
  - RESULT = quotient for DIV/DIVU, remainder for REM/REMU. Then DONE=1, go to DONE.
- DONE: DONE=0, go to IDLE. START in this state is ignored; the hazard unit holds the instruction.
- Latency (E0 = edge sampling START in IDLE):
  - Multiply: DONE high after E2.
  - Fast divide path: DONE high after E2.
  - Normal divide: DONE high after E34 (E1..E32 iterate, E33..E34 fix/DONE).
  - BUSY high between E1 and the edge raising DONE.
- The hazard unit stalls on (START & IDLE) | BUSY.
- START while BUSY or in DONE is ignored; operands are not re-latched.
- KILL in MUL/DIV/FIX goes to IDLE at the next edge: no DONE, RESULT unchanged. KILL in IDLE or DONE has no effect beyond the normal transition.
- KILL and START both high in IDLE: KILL wins, request not accepted.
- Counter never wraps; it saturates at XLEN.

Decomposition:
- Package mdu_pkg holds:
  - mdu_op_e enum (8 funct3 codes above)
  - mdu_state_e enum
  - XLEN_DEF constant
  - INT_MIN constant (0x80000000)
  - NEG_ONE constant (0xFFFFFFFF)
- Sub-module mdu_div_core holds the iterative restoring divider datapath (remainder/quotient shift registers plus trial subtractor). It is controlled by the mdu_unit state machine through step/load inputs.

Test Plan:
- MUL 7 × 0xFFFFFFFD → RESULT 0xFFFFFFEB; DONE one pulse after E2; BUSY high exactly 1 cycle.
- Multiply high variants:
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE
  - MULH same operands → 0x00000000
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF
- Signed divide:
  - DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD
  - REM 0xFFFFFFF9 % 2 → 0xFFFFFFFF
  - DONE after E34; BUSY high 33 cycles
- Corner cases:
  - DIVU 5/0 → 0xFFFFFFFF and REMU 5/0 → 5, each DONE after E2
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM of the same → 0
- DIVU 100/7 with KILL at E10 → IDLE at E11, no DONE, RESULT keeps its prior value; new DIVU 100/7 → 14, then REMU 100/7 → 2.
- Reset and ignore rules:
  - RST at E15 mid-DIV → BUSY=0, DONE=0, RESULT=0 next cycle.
  - START pulsed while BUSY → ignored; original result delivered; no second DONE.
